// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave bridging software accesses onto a bank of hardware registers.
// Writes produce a one-cycle one-hot enable pulse plus data toward the bank;
// reads sample the bank's concatenated value bus. Read and write channels are
// handled by two independent two-state FSMs so they never stall each other.
module axil_reg_bridge #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_WIDTH = 8,
    parameter int                   NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic                           CLK,
    input  logic                           RST,

    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,

    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,

    output logic [NUM_REGS-1:0]            REG_WEN,
    output logic [DATA_WIDTH-1:0]          REG_WDATA,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] REG_RDATA
);

    localparam int         IDX_W       = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t                w_state;
    r_state_t                r_state;

    logic [IDX_W-1:0]        aw_idx;
    logic [IDX_W-1:0]        ar_idx;
    logic [NUM_REGS-1:0]     aw_onehot;
    logic                    aw_ok;
    logic                    aw_accept;
    logic [DATA_WIDTH-1:0]   ar_data;
    logic                    ar_hit;
    logic                    unused_addr_lsbs;

    // Byte-offset bits are irrelevant for full-word registers.
    assign aw_idx           = AWADDR[ADDR_WIDTH-1:2];
    assign ar_idx           = ARADDR[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    // Decode the write target into a one-hot enable; out-of-range and
    // read-only targets decode to all zeros, which also flags the error.
    always_comb begin
        aw_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx == IDX_W'(i) && !RO_MASK[i]) begin
                aw_onehot[i] = 1'b1;
            end
        end
    end

    assign aw_ok = |aw_onehot;

    // Select the addressed register value; a miss yields zero data.
    always_comb begin
        ar_data = '0;
        ar_hit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                ar_data = REG_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
                ar_hit  = 1'b1;
            end
        end
    end

    // Address and data are only taken together, and only while idle.
    assign aw_accept = (w_state == W_IDLE) && AWVALID && WVALID && !RST;
    assign AWREADY   = aw_accept;
    assign WREADY    = aw_accept;

    // Write channel: latch data, fire the enable pulse for one cycle and hold
    // the response until the master takes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state   <= W_IDLE;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            REG_WEN   <= '0;
            REG_WDATA <= '0;
        end else begin
            REG_WEN <= '0;
            case (w_state)
                W_IDLE: begin
                    if (aw_accept) begin
                        REG_WDATA <= WDATA;
                        REG_WEN   <= aw_onehot;
                        BRESP     <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                        BVALID    <= 1'b1;
                        w_state   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    BVALID  <= 1'b0;
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel: capture the addressed value on the address handshake and
    // hold it stable until the master accepts it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RRESP   <= RESP_OKAY;
            RDATA   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        RDATA   <= ar_data;
                        RRESP   <= ar_hit ? RESP_OKAY : RESP_SLVERR;
                        RVALID  <= 1'b1;
                        ARREADY <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        ARREADY <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    RVALID  <= 1'b0;
                    ARREADY <= 1'b0;
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed bench for axil_reg_bridge. Stimulus tasks push expected responses
// into queues; a negedge monitor pops and compares whenever the DUT presents
// a write-enable pulse, a write response or a read response.
module tb_axil_reg_bridge;

    localparam int        DW = 32;
    localparam int        AW = 8;
    localparam int        NR = 8;
    localparam logic [NR-1:0] RO = 8'h80;

    logic            CLK = 1'b0;
    logic            RST;
    logic [AW-1:0]   AWADDR;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;
    logic [NR-1:0]   REG_WEN;
    logic [DW-1:0]   REG_WDATA;
    logic [NR*DW-1:0] REG_RDATA;

    logic [DW-1:0]   bank [NR];

    typedef struct packed {
        logic [NR-1:0] wen;
        logic [DW-1:0] data;
    } wen_exp_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } r_exp_t;

    wen_exp_t   wen_q [$];
    logic [1:0] b_q   [$];
    r_exp_t     r_q   [$];

    int checks   = 0;
    int failures = 0;

    axil_reg_bridge #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .RO_MASK    (RO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .AWADDR    (AWADDR),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .ARADDR    (ARADDR),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .REG_WEN   (REG_WEN),
        .REG_WDATA (REG_WDATA),
        .REG_RDATA (REG_RDATA)
    );

    always #5 CLK = ~CLK;

    // Flatten the modelled register bank onto the DUT's read bus.
    always_comb begin
        REG_RDATA = '0;
        for (int i = 0; i < NR; i++) begin
            REG_RDATA[i*DW +: DW] = bank[i];
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: every observed pulse or response consumes one
    // expectation; anything observed with nothing queued is an error.
    always @(negedge CLK) begin
        wen_exp_t   we;
        r_exp_t     re;
        logic [1:0] be;
        if (!RST) begin
            if (REG_WEN !== '0) begin
                if (wen_q.size() == 0) begin
                    check_output("wen_unexpected", 64'(REG_WEN), 64'd0);
                end else begin
                    we = wen_q.pop_front();
                    check_output("reg_wen", 64'(REG_WEN), 64'(we.wen));
                    check_output("reg_wdata", 64'(REG_WDATA), 64'(we.data));
                end
                check_output("bvalid_with_wen", 64'(BVALID), 64'd1);
            end
            if (BVALID && BREADY) begin
                if (b_q.size() == 0) begin
                    check_output("b_unexpected", 64'(BVALID), 64'd0);
                end else begin
                    be = b_q.pop_front();
                    check_output("bresp", 64'(BRESP), 64'(be));
                end
            end
            if (RVALID && RREADY) begin
                if (r_q.size() == 0) begin
                    check_output("r_unexpected", 64'(RVALID), 64'd0);
                end else begin
                    re = r_q.pop_front();
                    check_output("rdata", 64'(RDATA), 64'(re.data));
                    check_output("rresp", 64'(RRESP), 64'(re.resp));
                end
            end
        end
    end

    // Issue one write; optionally present AW alone first and stall BREADY.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int aw_lead, input int bready_delay,
                            input logic [NR-1:0] exp_wen, input logic [1:0] exp_resp);
        wen_exp_t we;
        bit       got;
        AWADDR  = addr;
        WDATA   = data;
        AWVALID = 1'b1;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        for (int i = 0; i < aw_lead; i++) begin
            #1;
            check_output("awready_lone", 64'(AWREADY), 64'd0);
            check_output("wready_lone", 64'(WREADY), 64'd0);
            tick();
        end
        WVALID = 1'b1;
        if (exp_wen != '0) begin
            we.wen  = exp_wen;
            we.data = data;
            wen_q.push_back(we);
        end
        b_q.push_back(exp_resp);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (AWREADY && WREADY) got = 1'b1;
            tick();
        end
        if (!got) check_output("aw_timeout", 64'(AWREADY), 64'd1);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        #1;
        check_output("bvalid_latency", 64'(BVALID), 64'd1);
        for (int i = 0; i < bready_delay; i++) begin
            tick();
            check_output("bvalid_held", 64'(BVALID), 64'd1);
            check_output("bresp_held", 64'(BRESP), 64'(exp_resp));
            check_output("awready_busy", 64'(AWREADY), 64'd0);
        end
        BREADY = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (BVALID) got = 1'b1;
            tick();
        end
        if (!got) check_output("b_timeout", 64'(BVALID), 64'd1);
        BREADY = 1'b0;
    endtask

    // Issue one read; optionally stall RREADY while checking RDATA stays put.
    task automatic do_read(input logic [AW-1:0] addr, input int rready_delay,
                           input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
        r_exp_t re;
        bit     got;
        ARADDR  = addr;
        ARVALID = 1'b1;
        RREADY  = 1'b0;
        re.data = exp_data;
        re.resp = exp_resp;
        r_q.push_back(re);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (ARREADY) got = 1'b1;
            tick();
        end
        if (!got) check_output("ar_timeout", 64'(ARREADY), 64'd1);
        ARVALID = 1'b0;
        #1;
        check_output("rvalid_latency", 64'(RVALID), 64'd1);
        check_output("arready_busy", 64'(ARREADY), 64'd0);
        for (int i = 0; i < rready_delay; i++) begin
            tick();
            check_output("rvalid_held", 64'(RVALID), 64'd1);
            check_output("rdata_held", 64'(RDATA), 64'(exp_data));
        end
        RREADY = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (RVALID) got = 1'b1;
            tick();
        end
        if (!got) check_output("r_timeout", 64'(RVALID), 64'd1);
        RREADY = 1'b0;
        #1;
        check_output("arready_return", 64'(ARREADY), 64'd1);
    endtask

    // Hard time limit so a wedged handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        RST     = 1'b1;
        AWADDR  = '0;
        AWVALID = 1'b0;
        WDATA   = '0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        ARADDR  = '0;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        for (int i = 0; i < NR; i++) bank[i] = 32'h1000_0000 + 32'(i);
        bank[7] = 32'hCAFE_0001;
        bank[1] = 32'h0000_0011;

        repeat (3) tick();
        check_output("rst_awready", 64'(AWREADY), 64'd0);
        check_output("rst_wready", 64'(WREADY), 64'd0);
        check_output("rst_bvalid", 64'(BVALID), 64'd0);
        check_output("rst_bresp", 64'(BRESP), 64'd0);
        check_output("rst_arready", 64'(ARREADY), 64'd0);
        check_output("rst_rvalid", 64'(RVALID), 64'd0);
        check_output("rst_rresp", 64'(RRESP), 64'd0);
        check_output("rst_rdata", 64'(RDATA), 64'd0);
        check_output("rst_reg_wen", 64'(REG_WEN), 64'd0);
        check_output("rst_reg_wdata", 64'(REG_WDATA), 64'd0);
        RST = 1'b0;
        tick();
        check_output("arready_after_rst", 64'(ARREADY), 64'd1);

        $display("[TB] basic write to register 2");
        do_write(8'h08, 32'hDEAD_BEEF, 0, 0, 8'b0000_0100, 2'b00);

        $display("[TB] read-only register 7");
        do_write(8'h1C, 32'h0000_1234, 0, 0, 8'b0000_0000, 2'b10);
        do_read(8'h1C, 0, 32'hCAFE_0001, 2'b00);

        $display("[TB] out-of-range address");
        do_read(8'h20, 0, 32'h0000_0000, 2'b10);
        do_write(8'h20, 32'h0000_5678, 0, 0, 8'b0000_0000, 2'b10);

        $display("[TB] lone AWVALID then stalled BREADY");
        do_write(8'h10, 32'hA5A5_0010, 5, 3, 8'b0001_0000, 2'b00);

        $display("[TB] byte offset ignored");
        do_write(8'h0F, 32'h0000_00F3, 0, 0, 8'b0000_1000, 2'b00);
        do_read(8'h03, 0, 32'h1000_0000, 2'b00);

        $display("[TB] concurrent read and write to register 1");
        fork
            do_read(8'h04, 4, 32'h0000_0011, 2'b00);
            do_write(8'h04, 32'h0000_0022, 0, 0, 8'b0000_0010, 2'b00);
            begin
                repeat (2) tick();
                bank[1] = 32'h0000_0022;
            end
        join
        do_read(8'h04, 0, 32'h0000_0022, 2'b00);

        $display("[TB] reset during pending responses");
        AWADDR  = 8'h0C;
        WDATA   = 32'h5555_AAAA;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        BREADY  = 1'b0;
        ARADDR  = 8'h0C;
        ARVALID = 1'b1;
        RREADY  = 1'b0;
        wen_q.push_back(wen_exp_t'{wen: 8'b0000_1000, data: 32'h5555_AAAA});
        #1;
        check_output("mid_awready", 64'(AWREADY), 64'd1);
        check_output("mid_arready", 64'(ARREADY), 64'd1);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        #1;
        check_output("mid_bvalid", 64'(BVALID), 64'd1);
        check_output("mid_rvalid", 64'(RVALID), 64'd1);
        tick();
        check_output("mid_bvalid_held", 64'(BVALID), 64'd1);
        check_output("mid_wen_done", 64'(REG_WEN), 64'd0);
        RST = 1'b1;
        tick();
        check_output("rst2_bvalid", 64'(BVALID), 64'd0);
        check_output("rst2_rvalid", 64'(RVALID), 64'd0);
        check_output("rst2_reg_wen", 64'(REG_WEN), 64'd0);
        check_output("rst2_arready", 64'(ARREADY), 64'd0);
        check_output("rst2_awready", 64'(AWREADY), 64'd0);
        check_output("rst2_rdata", 64'(RDATA), 64'd0);
        RST = 1'b0;
        tick();

        $display("[TB] fresh transactions after reset");
        do_write(8'h0C, 32'h0BAD_F00D, 0, 0, 8'b0000_1000, 2'b00);
        do_read(8'h0C, 0, 32'h1000_0003, 2'b00);

        repeat (5) tick();
        check_output("wen_q_drained", 64'(wen_q.size()), 64'd0);
        check_output("b_q_drained", 64'(b_q.size()), 64'd0);
        check_output("r_q_drained", 64'(r_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
